// File: rtl/sakebi_ether_pkg.sv
// rtl/sakebi_ether_pkg.sv - shared Ethernet II framing constants, states and helpers
//
// Purpose: common definitions for the Ethernet II frame TX and RX blocks.
//   - framer state encoding
//   - header field sizes and minimum payload length
//   - well-known EtherType values
//   - saturating payload byte counter increment
package sakebi_ether_pkg;

  localparam int MAC_BYTES       = 6;
  localparam int ETHERTYPE_BYTES = 2;
  localparam int MIN_PAYLOAD     = 46;
  localparam int PAY_CNT_WIDTH   = 11;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_PAYLOAD,
    ST_PAD,
    ST_WAIT_LAST
  } ether_state_t;

  // Payload counter sticks at all-ones so jumbo frames never wrap back
  // below the padding threshold.
  function automatic logic [PAY_CNT_WIDTH-1:0] pay_cnt_inc(
    input logic [PAY_CNT_WIDTH-1:0] cnt
  );
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/sakebi_ethernet_frame_tx_if.sv
// rtl/sakebi_ethernet_frame_tx_if.sv - byte stream handshake interface
//
// Purpose: groups one stream link (valid/ready/data/last).
// Signals:
//   TVALID  producer has a beat
//   TREADY  consumer accepts the beat
//   TDATA   beat byte
//   TLAST   final beat of a frame
// Modports:
//   master  producer side (drives TVALID/TDATA/TLAST)
//   slave   consumer side (drives TREADY)
interface sakebi_ethernet_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;

  modport master (output TVALID, output TDATA, output TLAST, input TREADY);
  modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface

// File: rtl/sakebi_axis_out_reg.sv
// rtl/sakebi_axis_out_reg.sv - single-stage registered stream output with stall hold
//
// Purpose: one register stage driving a stream master. The stage holds its
// beat while the consumer stalls and reports when it can take a new beat.
// Ports:
//   i_axis_ACLK     clock
//   i_axis_ARESETn  asynchronous active-low reset
//   ld_valid        a new beat is offered this cycle (taken only when adv)
//   ld_data         byte of the offered beat
//   ld_last         TLAST of the offered beat
//   adv             stage can load this cycle (!TVALID || TREADY)
//   m_axis          stream master output
module sakebi_axis_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                              i_axis_ACLK,
  input  logic                              i_axis_ARESETn,
  input  logic                              ld_valid,
  input  logic [DATA_WIDTH-1:0]             ld_data,
  input  logic                              ld_last,
  output logic                              adv,
  sakebi_ethernet_frame_tx_if.master        m_axis
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  assign adv = !valid_q || m_axis.TREADY;

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= ld_valid;
      last_q  <= ld_valid & ld_last;
      // Data is only refreshed on a real beat so an idle stage keeps the
      // previous byte rather than toggling the bus.
      if (ld_valid) begin
        data_q <= ld_data;
      end
    end
  end

  assign m_axis.TVALID = valid_q;
  assign m_axis.TDATA  = data_q;
  assign m_axis.TLAST  = last_q;

endmodule

// File: rtl/sakebi_ethernet_frame_tx.sv
// rtl/sakebi_ethernet_frame_tx.sv - Ethernet II frame transmitter (header + padded payload)
//
// Purpose: prefixes a payload stream with dst MAC, src MAC and EtherType and
// zero-pads the payload to the minimum length. No FCS is produced.
// Ports:
//   i_axis_ACLK     clock
//   i_axis_ARESETn  asynchronous active-low reset
//   s_axis          payload stream in (TREADY only asserted in payload phase)
//   m_axis          frame stream out (registered)
//   i_dst_mac_addr  destination MAC, byte [7:0] sent first
//   i_src_mac_addr  source MAC, byte [7:0] sent first
//   i_ethertype     EtherType, byte [7:0] sent first
//   o_busy          frame in progress until the last output beat is accepted
//   o_frame_done    one-cycle pulse after the TLAST beat is accepted
module sakebi_ethernet_frame_tx
  import sakebi_ether_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MAC_ADDR_WIDTH  = DATA_WIDTH * 6,
  parameter int ETHERTYPE_WIDTH = DATA_WIDTH * 2,
  parameter int MIN_PAYLOAD     = sakebi_ether_pkg::MIN_PAYLOAD
) (
  input  logic                       i_axis_ACLK,
  input  logic                       i_axis_ARESETn,
  sakebi_ethernet_frame_tx_if.slave  s_axis,
  sakebi_ethernet_frame_tx_if.master m_axis,
  input  logic [MAC_ADDR_WIDTH-1:0]  i_dst_mac_addr,
  input  logic [MAC_ADDR_WIDTH-1:0]  i_src_mac_addr,
  input  logic [ETHERTYPE_WIDTH-1:0] i_ethertype,
  output logic                       o_busy,
  output logic                       o_frame_done
);

  localparam int CNT_W = PAY_CNT_WIDTH + 1;

  ether_state_t               state, state_nxt;
  logic [2:0]                 idx, idx_nxt;
  logic [PAY_CNT_WIDTH-1:0]   pay_cnt, pay_cnt_nxt;
  logic [MAC_ADDR_WIDTH-1:0]  dst_q, src_q;
  logic [ETHERTYPE_WIDTH-1:0] type_q;
  logic                       busy_nxt;
  logic                       frame_done_nxt;
  logic                       hdr_latch;
  logic                       s_ready;

  logic                       ld_valid;
  logic [DATA_WIDTH-1:0]      ld_data;
  logic                       ld_last;
  logic                       adv;

  // Byte count including the beat being loaded now; one bit wider so the
  // threshold compare is exact even when pay_cnt is saturated.
  logic [CNT_W-1:0]           pay_cnt_p1;
  logic                       reach_min;

  assign pay_cnt_p1 = {1'b0, pay_cnt} + CNT_W'(1);
  assign reach_min  = pay_cnt_p1 >= CNT_W'(MIN_PAYLOAD);

  sakebi_axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .i_axis_ACLK    (i_axis_ACLK),
    .i_axis_ARESETn (i_axis_ARESETn),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .adv            (adv),
    .m_axis         (m_axis)
  );

  assign s_axis.TREADY = s_ready;

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state        <= ST_IDLE;
      idx          <= '0;
      pay_cnt      <= '0;
      dst_q        <= '0;
      src_q        <= '0;
      type_q       <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      pay_cnt      <= pay_cnt_nxt;
      o_busy       <= busy_nxt;
      o_frame_done <= frame_done_nxt;
      if (hdr_latch) begin
        dst_q  <= i_dst_mac_addr;
        src_q  <= i_src_mac_addr;
        type_q <= i_ethertype;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    pay_cnt_nxt    = pay_cnt;
    busy_nxt       = o_busy;
    frame_done_nxt = 1'b0;
    hdr_latch      = 1'b0;
    s_ready        = 1'b0;
    ld_valid       = 1'b0;
    ld_data        = '0;
    ld_last        = 1'b0;

    case (state)
      ST_IDLE: begin
        // The first payload beat only announces the frame; it is consumed
        // later in the payload phase.
        if (s_axis.TVALID) begin
          hdr_latch   = 1'b1;
          idx_nxt     = '0;
          pay_cnt_nxt = '0;
          busy_nxt    = 1'b1;
          state_nxt   = ST_DST;
        end
      end

      ST_DST: begin
        if (adv) begin
          ld_valid = 1'b1;
          ld_data  = dst_q[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
          if (idx == 3'(MAC_BYTES - 1)) begin
            idx_nxt   = '0;
            state_nxt = ST_SRC;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end

      ST_SRC: begin
        if (adv) begin
          ld_valid = 1'b1;
          ld_data  = src_q[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
          if (idx == 3'(MAC_BYTES - 1)) begin
            idx_nxt   = '0;
            state_nxt = ST_TYPE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end

      ST_TYPE: begin
        if (adv) begin
          ld_valid = 1'b1;
          ld_data  = type_q[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
          if (idx == 3'(ETHERTYPE_BYTES - 1)) begin
            idx_nxt   = '0;
            state_nxt = ST_PAYLOAD;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        s_ready = adv;
        if (adv && s_axis.TVALID) begin
          ld_valid    = 1'b1;
          ld_data     = s_axis.TDATA;
          pay_cnt_nxt = pay_cnt_inc(pay_cnt);
          if (s_axis.TLAST) begin
            if (reach_min) begin
              ld_last   = 1'b1;
              state_nxt = ST_WAIT_LAST;
            end else begin
              state_nxt = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        if (adv) begin
          ld_valid    = 1'b1;
          ld_data     = '0;
          pay_cnt_nxt = pay_cnt_inc(pay_cnt);
          if (reach_min) begin
            ld_last   = 1'b1;
            state_nxt = ST_WAIT_LAST;
          end
        end
      end

      ST_WAIT_LAST: begin
        // Only the TLAST beat can be in the stage here, so any accept ends
        // the frame.
        if (m_axis.TVALID && m_axis.TREADY) begin
          frame_done_nxt = 1'b1;
          busy_nxt       = 1'b0;
          state_nxt      = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sakebi_ethernet_frame_tx.sv
// tb/tb_sakebi_ethernet_frame_tx.sv - randomized self-checking bench for the frame transmitter
module tb_sakebi_ethernet_frame_tx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] ethertype = '0;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  sakebi_ethernet_frame_tx_if #(.DATA_WIDTH(8)) s_if ();
  sakebi_ethernet_frame_tx_if #(.DATA_WIDTH(8)) m_if ();

  sakebi_ethernet_frame_tx dut (
    .i_axis_ACLK    (clk),
    .i_axis_ARESETn (resetn),
    .s_axis         (s_if.slave),
    .m_axis         (m_if.master),
    .i_dst_mac_addr (dst_mac),
    .i_src_mac_addr (src_mac),
    .i_ethertype    (ethertype),
    .o_busy         (busy),
    .o_frame_done   (frame_done)
  );

  int pass_cnt = 0;
  int check_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: the expected output beats {tlast, byte} of all queued frames.
  logic [8:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] pay[$];
  int         beats_cur = 0;
  int         last_len = 0;
  int         done_cnt = 0;
  bit         chk_en = 0;
  bit         stall_prev = 0;
  bit         done_exp = 0;
  logic [7:0] hold_data;
  logic       hold_last;
  bit         rdy_rand = 0;

  initial begin
    m_if.TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.TREADY = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (chk_en && resetn) begin
      if (stall_prev) begin
        check("hold_valid", m_if.TVALID, 1);
        check("hold_data", m_if.TDATA, hold_data);
        check("hold_last", m_if.TLAST, hold_last);
      end
      if (frame_done || done_exp) check("frame_done", frame_done, done_exp);
      if (frame_done) done_cnt++;
      if (m_if.TVALID && !busy) check("busy_while_valid", busy, 1);
      if (s_if.TREADY) begin
        check("in_ready_busy", busy, 1);
        check("in_ready_after_header", beats_cur >= 13, 1);
      end
      done_exp = 0;
      if (m_if.TVALID && m_if.TREADY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_if.TDATA, e[7:0]);
          check("out_last", m_if.TLAST, e[8]);
        end
        cap_q.push_back(m_if.TDATA);
        beats_cur++;
        if (m_if.TLAST) begin
          last_len = beats_cur;
          beats_cur = 0;
          done_exp = 1;
        end
      end
      stall_prev = m_if.TVALID && !m_if.TREADY;
      hold_data = m_if.TDATA;
      hold_last = m_if.TLAST;
    end
  end

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] t, input bit gaps);
    int n;
    int tot;
    int guard;
    bit hs;
    n = pay.size();
    tot = (n < 46) ? 46 : n;
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, d[i*8 +: 8]});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, s[i*8 +: 8]});
    for (int i = 0; i < 2; i++) exp_q.push_back({1'b0, t[i*8 +: 8]});
    for (int i = 0; i < tot; i++) exp_q.push_back({(i == tot - 1), (i < n) ? pay[i] : 8'h00});
    dst_mac = d;
    src_mac = s;
    ethertype = t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_if.TVALID = 1'b0;
          @(posedge clk);
          #2;
        end
      end
      s_if.TVALID = 1'b1;
      s_if.TDATA = pay[i];
      s_if.TLAST = (i == n - 1);
      hs = 0;
      guard = 0;
      while (!hs && guard < 3000) begin
        @(negedge clk);
        hs = s_if.TREADY;
        @(posedge clk);
        #2;
        guard++;
      end
      if (!hs) check("in_handshake_timeout", 0, 1);
      if (i == 0) begin
        // Header has been latched by now; scramble the inputs.
        dst_mac = {$urandom, $urandom};
        src_mac = {$urandom, $urandom};
        ethertype = 16'($urandom);
      end
    end
    s_if.TVALID = 1'b0;
    s_if.TLAST = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic fill_inc(input int n, input logic [7:0] base);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(base + i));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, m_if.TVALID, 0);
    check({tag, "_tdata"}, m_if.TDATA, 0);
    check({tag, "_tlast"}, m_if.TLAST, 0);
    check({tag, "_in_tready"}, s_if.TREADY, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] hdr_lit [14];
    int guard;
    int n;
    hdr_lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h08, 8'h00};
    s_if.TVALID = 1'b0;
    s_if.TDATA = '0;
    s_if.TLAST = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(posedge clk);
    #2;
    chk_en = 1;

    // 64-byte payload, no backpressure
    fill_inc(64, 8'h00);
    cap_q.delete();
    send_frame(48'h665544332211, 48'hCCBBAA998877, 16'h0008, 0);
    wait_drain();
    check("t1_len", last_len, 78);
    for (int i = 0; i < 14; i++) check("t1_hdr", cap_q[i], hdr_lit[i]);
    check("t1_last_byte", cap_q[77], 8'h3F);
    check("t1_done_pulses", done_cnt, 1);

    // 10-byte payload padded to 46
    fill_inc(10, 8'hA0);
    cap_q.delete();
    send_frame(48'h0A0B0C0D0E0F, 48'h010203040506, 16'h0608, 0);
    wait_drain();
    check("t2_len", last_len, 60);
    check("t2_first_pay", cap_q[14], 8'hA0);
    check("t2_last_pay", cap_q[23], 8'hA9);
    check("t2_first_pad", cap_q[24], 8'h00);

    // Boundary lengths
    fill_inc(46, 8'h10);
    send_frame(48'h1, 48'h2, 16'h0008, 0);
    wait_drain();
    check("t3_len46", last_len, 60);
    fill_inc(47, 8'h20);
    cap_q.delete();
    send_frame(48'h3, 48'h4, 16'h0008, 0);
    wait_drain();
    check("t4_len47", last_len, 61);
    check("t4_last_byte", cap_q[60], 8'h4E);

    // Same 64-byte frame under random stalls and upstream gaps
    rdy_rand = 1;
    fill_inc(64, 8'h00);
    send_frame(48'h665544332211, 48'hCCBBAA998877, 16'h0008, 1);
    wait_drain();
    check("t5_len", last_len, 78);

    // Back-to-back frames, then random frames
    fill_inc(20, 8'h40);
    send_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 0);
    fill_inc(50, 8'h80);
    send_frame(48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6, 16'h0806, 0);
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 80);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 1);
    end
    wait_drain();
    check("random_done_pulses", done_cnt, 13);

    // Reset in the middle of the src MAC bytes
    rdy_rand = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 0;
    dst_mac = 48'h0F0E0D0C0B0A;
    src_mac = 48'h1F1E1D1C1B1A;
    ethertype = 16'h0008;
    s_if.TVALID = 1'b1;
    s_if.TDATA = 8'h55;
    s_if.TLAST = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(m_if.TVALID && m_if.TDATA == 8'h1C) && guard < 100);
    check("reach_src_bytes", guard < 100, 1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    s_if.TVALID = 1'b0;
    s_if.TLAST = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("no_resume_valid", m_if.TVALID, 0);
    check("no_resume_busy", busy, 0);
    exp_q.delete();
    cap_q.delete();
    beats_cur = 0;
    stall_prev = 0;
    done_exp = 0;
    @(posedge clk);
    #2;
    chk_en = 1;
    pay.delete();
    pay.push_back(8'h5A);
    send_frame(48'h665544332211, 48'hCCBBAA998877, 16'h0008, 0);
    wait_drain();
    check("post_reset_len", last_len, 60);
    check("post_reset_pay", cap_q[14], 8'h5A);
    check("post_reset_pad", cap_q[59], 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
